// File: rtl/norm2_arb_pkg.sv
// Shared types and widths for the norm2 request arbiter.
package norm2_arb_pkg;

  localparam int VEC_W  = 128;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/norm2_rr_picker.sv
// Combinational round-robin selection: the first set bit of req at or after
// rr_ptr, scanning upward and wrapping at NREQ.
module norm2_rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan NREQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int               j;
    logic [ID_W-1:0]  jj;
    j     = 0;
    jj    = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = ID_W'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/norm2_arbiter.sv
// Shares one norm2 engine between NREQ requesters with round-robin grants and
// a single operation in flight.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready is a combinational response to the current state and
// inputs, valid from the producer does not depend on ready.
// Optional per-requester grant counters are built when NORM2_ARB_STATS_EN is
// defined; otherwise grant_cnt is tied to zero.
module norm2_arbiter
  import norm2_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*VEC_W-1:0] req_vector,
  output logic [NREQ-1:0]       req_ready,
  output logic [VEC_W-1:0]      eng_vector,
  output logic                  eng_enable,
  input  logic                  eng_accept_out,
  input  logic                  eng_ready_out,
  input  logic [DATA_W-1:0]     eng_res,
  output logic                  eng_accept_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy,
  output logic [NREQ*CNT_W-1:0] grant_cnt
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            grant_fire;
  logic [VEC_W-1:0] sel_vec;

  norm2_rr_picker #(.NREQ(NREQ), .ID_W(ID_W)) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A grant is only offered in IDLE and never while reset is being applied.
  assign grant_fire = (state == ST_IDLE) && pick_any && !reset;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  // Operand of the winning requester.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_grant[i]) sel_vec = req_vector[i*VEC_W +: VEC_W];
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    eng_enable    = 1'b0;
    eng_accept_in = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_fire) begin
          req_ready = pick_grant;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        eng_enable = eng_accept_out;
        if (eng_accept_out) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        eng_accept_in = eng_ready_out;
        if (eng_ready_out) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, round-robin pointer, latched operand/ID and captured result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      eng_vector <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        eng_vector <= sel_vec;
        rsp_id     <= pick_idx;
        rr_ptr     <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
      if (state == ST_WAIT && eng_ready_out) rsp_data <= eng_res;
    end
  end

`ifdef NORM2_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (grant_fire && pick_grant[i] && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
